// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures i_clk_in period in i_clk cycles with lock/timeout reporting
// Optional high-phase measurement enabled by defining CLK_PERIOD_METER_HIGH_TIME_EN.
module clk_period_meter #(
    parameter int SIZE        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_PERIOD  = 65535,
    parameter int TOLERANCE   = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic            i_clk_in,
    output logic [SIZE-1:0] o_period,
    output logic            o_valid,
    output logic            o_locked,
    output logic            o_timeout,
    output logic [SIZE-1:0] o_high_time
);

    localparam logic [SIZE-1:0] LAST_COUNT = SIZE'(MAX_PERIOD - 1);
    localparam logic [SIZE-1:0] TOL        = SIZE'(TOLERANCE);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, TIMEOUT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [SIZE-1:0]        counter;
    logic [SIZE-1:0]        prev_period;
    logic                   has_prev;
    logic [SIZE-1:0]        next_period;
    logic [SIZE-1:0]        delta;
    logic                   synced;
    logic                   rise;

    assign synced      = sync_q[SYNC_STAGES-1];
    assign rise        = synced & ~hist_q;
    assign next_period = counter + SIZE'(1);
    assign delta       = (next_period >= prev_period) ? (next_period - prev_period)
                                                      : (prev_period - next_period);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_clk_in};
            hist_q <= synced;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            counter     <= '0;
            prev_period <= '0;
            has_prev    <= 1'b0;
            o_period    <= '0;
            o_valid     <= 1'b0;
            o_locked    <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            // Disable overrides everything, including a rise seen this same cycle.
            if (!i_enable) begin
                state     <= IDLE;
                counter   <= '0;
                has_prev  <= 1'b0;
                o_locked  <= 1'b0;
                o_timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        counter <= '0;
                        state   <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            counter  <= '0;
                            has_prev <= 1'b0;
                            state    <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            o_period    <= next_period;
                            o_valid     <= 1'b1;
                            prev_period <= next_period;
                            counter     <= '0;
                            o_locked    <= has_prev && (delta <= TOL);
                            has_prev    <= 1'b1;
                        end else if (counter == LAST_COUNT) begin
                            state     <= TIMEOUT;
                            o_timeout <= 1'b1;
                            o_locked  <= 1'b0;
                        end else begin
                            counter <= counter + SIZE'(1);
                        end
                    end
                    TIMEOUT: begin
                        o_locked <= 1'b0;
                        // The recovering edge only re-arms; the period before it is unknown.
                        if (rise) begin
                            o_timeout <= 1'b0;
                            counter   <= '0;
                            has_prev  <= 1'b0;
                            state     <= MEASURE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
    logic            fall;
    logic [SIZE-1:0] high_count;
    logic            high_run;

    assign fall = ~synced & hist_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            high_count  <= '0;
            high_run    <= 1'b0;
            o_high_time <= '0;
        end else if (!i_enable) begin
            high_count  <= '0;
            high_run    <= 1'b0;
            o_high_time <= '0;
        end else if (rise && state != IDLE) begin
            high_count <= '0;
            high_run   <= 1'b1;
        end else if (state == MEASURE && high_run) begin
            if (fall) begin
                o_high_time <= high_count + SIZE'(1);
                high_run    <= 1'b0;
            end else if (high_count != LAST_COUNT) begin
                high_count <= high_count + SIZE'(1);
            end
        end
    end
`else
    assign o_high_time = '0;
`endif

endmodule
